ball_physics_engine: RTL
========================

Name: ball_physics_engine

Overview:
Frame-stepped ball motion and collision engine for the paddle game; successor to the combinational collision check. Each frame tick moves the ball by a speed step, tests the candidate position against NUM_PADDLES paddles, side walls, ceiling and floor, reflects direction, and reports hit/miss events. It sits between the paddle controllers and the renderer and owns the ball position.

Parameters:
BIT_WIDTH, 10, coordinate width (unsigned pixels, Y grows downward)
BALL_RADIUS, 5, ball half-extent
PADDLE_RADIUS, 20, paddle half-length in Y
NUM_PADDLES, 2, paddle count (>=1)
SCREEN_W, 640, screen width; right wall at SCREEN_W-1
CEIL_Y, 0, ceiling Y
FLOOR_Y, 479, floor Y
SPEED_WIDTH, 4, speed input width
HIT_CNT_WIDTH, 8, hit counter width
START_X, 320, parked ball X
START_Y, 240, parked ball Y

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
frameTick  in  1  one-cycle pulse per video frame
serve  in  1  launch request
serveDirX  in  1  launch X direction (1 = right)
speed  in  SPEED_WIDTH  pixels per frame on each axis
paddleX  in  NUM_PADDLES*BIT_WIDTH  packed paddle centres X, paddle 0 in LSBs
paddleY  in  NUM_PADDLES*BIT_WIDTH  packed paddle centres Y
ballX  out  BIT_WIDTH  committed ball X
ballY  out  BIT_WIDTH  committed ball Y
ballActive  out  1  ball in play
hitPaddle  out  NUM_PADDLES  one-hot one-cycle pulse, paddle hit
floorHit  out  1  one-cycle pulse, ball missed (floor reached)
hitCount  out  HIT_CNT_WIDTH  paddle hits this rally, saturating

Behaviour:
- One clock, clk; reset is synchronous and active-high.
- Reset (any state, mid-step included): state IDLE, ballX=START_X, ballY=START_Y, dirX=right, dirY=down, ballActive=0, hitPaddle=0, floorHit=0, hitCount=0.
- FSM IDLE -> MOVE -> STEP -> CHECK -> MOVE.
- IDLE: ball parked, ballActive=0. serve=1 -> MOVE, dirX=serveDirX, dirY=down, hitCount=0. frameTick ignored. serve ignored in every other state.
- MOVE: ballActive=1. frameTick=1 -> STEP. frameTick and serve in same IDLE cycle: serve only.
- STEP: register candidate nx=ballX±speed, ny=ballY±speed, computed BIT_WIDTH+2 signed (no wrap), speed sampled here. speed=0 still runs CHECK.
- CHECK (commits; ballX/ballY change exactly 2 cycles after the frameTick cycle):
  1. Floor: ny+BALL_RADIUS >= FLOOR_Y -> floorHit=1, ball to START, -> IDLE. Highest priority; suppresses paddle hit.
  2. Paddle i: |nx-paddleX_i| <= BALL_RADIUS and |ny-paddleY_i| <= PADDLE_RADIUS and ball moving toward paddle (paddleX_i < SCREEN_W/2 requires dirX=left, else right) -> flip dirX, hitPaddle[i]=1, hitCount+1 (saturate at all-ones). Lowest index wins if several match; at most one bit set.
  3. Side walls: nx-BALL_RADIUS <= 0 -> clamp nx=BALL_RADIUS, dirX=right; nx+BALL_RADIUS >= SCREEN_W-1 -> clamp nx=SCREEN_W-1-BALL_RADIUS, dirX=left. Skipped if paddle hit this step.
  4. Ceiling: ny-BALL_RADIUS <= CEIL_Y -> clamp ny=CEIL_Y+BALL_RADIUS, dirY=down. Independent of 2/3 (corner flips both).
  5. Commit ballX=nx, ballY=ny (post-clamp), -> MOVE.
- frameTick arriving in STEP/CHECK is dropped (no queue).
- hitPaddle/floorHit high only in the CHECK commit cycle; 0 otherwise.
- Paddle inputs sampled combinationally in CHECK; no internal copy.

Decomposition:
- Package pong_pkg: state enum (IDLE, MOVE, STEP, CHECK), direction typedef (DIR_LEFT/DIR_RIGHT, DIR_UP/DIR_DOWN), shared geometry defaults (BALL_RADIUS, PADDLE_RADIUS, FLOOR_Y, SCREEN_W).
- Sub-module paddle_hit_check: combinational per-paddle range test (nx, ny, paddle centre, dirX -> hit), generated NUM_PADDLES times; priority encode in parent.

Test Plan:
- Reset then frameTick x3 without serve -> ballX=320, ballY=240, ballActive=0, hitCount=0, no pulses.
- serve, serveDirX=1, speed=3, one frameTick -> two cycles later ballX=323, ballY=243, ballActive=1, no pulses.
- Paddle 1 at (600,240), ball (592,240) moving right/down, speed=3 -> nx=595, ny=243: hitPaddle=2'b10 one cycle, dirX left, hitCount=1; next step ballX=592. Same with paddleY=220 (ny=243 outside 200..240) -> no hit.
- Ball (320,7) moving up, speed=3 -> ballY=5, dirY down; next step ballY=8. Ball (7,100) moving left -> ballX=5, dirX right.
- Ball (320,472) moving down, speed=3 -> floorHit pulse, ballX=320, ballY=240, ballActive=0, state IDLE; also with paddle overlapping -> floorHit only, hitPaddle=0.
- Reset asserted in CHECK cycle -> next cycle all outputs at reset values, no pulse; hitCount at 255 plus hit -> stays 255.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and geometry defaults for the paddle-game ball engine.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MOVE  = 2'd1,
        STEP  = 2'd2,
        CHECK = 2'd3
    } state_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_x_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_y_t;

    localparam int DEF_BALL_RADIUS   = 5;
    localparam int DEF_PADDLE_RADIUS = 20;
    localparam int DEF_FLOOR_Y       = 479;
    localparam int DEF_SCREEN_W      = 640;

endpackage

// File: rtl/paddle_hit_check.sv
// Combinational contact test between a candidate ball position and one paddle,
// including the "ball must be heading toward this paddle" rule.
module paddle_hit_check
    import pong_pkg::*;
#(
    parameter int BIT_WIDTH     = 10,
    parameter int BALL_RADIUS   = DEF_BALL_RADIUS,
    parameter int PADDLE_RADIUS = DEF_PADDLE_RADIUS,
    parameter int SCREEN_W      = DEF_SCREEN_W
) (
    input  logic signed [BIT_WIDTH+1:0] nx,
    input  logic signed [BIT_WIDTH+1:0] ny,
    input  logic        [BIT_WIDTH-1:0] paddleX,
    input  logic        [BIT_WIDTH-1:0] paddleY,
    input  dir_x_t                      dirX,
    output logic                        hit
);
    localparam int CW = BIT_WIDTH + 2;
    localparam logic [CW:0]          X_REACH = (CW+1)'(BALL_RADIUS);
    localparam logic [CW:0]          Y_REACH = (CW+1)'(PADDLE_RADIUS);
    localparam logic [BIT_WIDTH-1:0] HALF_W  = BIT_WIDTH'(SCREEN_W / 2);

    // One extra bit so the difference of a signed candidate and an unsigned centre cannot overflow.
    logic [CW:0] dx, dy, adx, ady;
    logic        towardOk;

    assign dx  = {nx[CW-1], nx} - {3'b000, paddleX};
    assign dy  = {ny[CW-1], ny} - {3'b000, paddleY};
    assign adx = dx[CW] ? -dx : dx;
    assign ady = dy[CW] ? -dy : dy;

    assign towardOk = (paddleX < HALF_W) ? (dirX == DIR_LEFT) : (dirX == DIR_RIGHT);
    assign hit      = (adx <= X_REACH) && (ady <= Y_REACH) && towardOk;

endmodule

// File: rtl/ball_physics_engine.sv
// Frame-stepped ball motion: each frameTick moves the ball by speed on both axes,
// then resolves floor, paddle, wall and ceiling contacts and commits the result.
module ball_physics_engine
    import pong_pkg::*;
#(
    parameter int BIT_WIDTH     = 10,
    parameter int BALL_RADIUS   = DEF_BALL_RADIUS,
    parameter int PADDLE_RADIUS = DEF_PADDLE_RADIUS,
    parameter int NUM_PADDLES   = 2,
    parameter int SCREEN_W      = DEF_SCREEN_W,
    parameter int CEIL_Y        = 0,
    parameter int FLOOR_Y       = DEF_FLOOR_Y,
    parameter int SPEED_WIDTH   = 4,
    parameter int HIT_CNT_WIDTH = 8,
    parameter int START_X       = 320,
    parameter int START_Y       = 240
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               frameTick,
    input  logic                               serve,
    input  logic                               serveDirX,
    input  logic [SPEED_WIDTH-1:0]             speed,
    input  logic [NUM_PADDLES*BIT_WIDTH-1:0]   paddleX,
    input  logic [NUM_PADDLES*BIT_WIDTH-1:0]   paddleY,
    output logic [BIT_WIDTH-1:0]               ballX,
    output logic [BIT_WIDTH-1:0]               ballY,
    output logic                               ballActive,
    output logic [NUM_PADDLES-1:0]             hitPaddle,
    output logic                               floorHit,
    output logic [HIT_CNT_WIDTH-1:0]           hitCount,
    output state_t                             debugState
);
    localparam int CW = BIT_WIDTH + 2;
    localparam logic signed [CW-1:0] FLOOR_LIM = CW'(FLOOR_Y - BALL_RADIUS);
    localparam logic signed [CW-1:0] X_MIN     = CW'(BALL_RADIUS);
    localparam logic signed [CW-1:0] X_MAX     = CW'(SCREEN_W - 1 - BALL_RADIUS);
    localparam logic signed [CW-1:0] Y_MIN     = CW'(CEIL_Y + BALL_RADIUS);

    state_t state, nextState;
    dir_x_t dirX, cDirX;
    dir_y_t dirY, cDirY;
    logic signed [CW-1:0] nx, ny, bx, by, spd;
    logic [BIT_WIDTH-1:0]   cx, cy;
    logic [NUM_PADDLES-1:0] rawHit, hitSel;
    logic                   anyHit, floorReached;

    assign ballActive = (state != IDLE);
    assign debugState = state;

    // Candidate arithmetic is done two bits wider than a coordinate so it never wraps.
    assign bx  = $signed({2'b00, ballX});
    assign by  = $signed({2'b00, ballY});
    assign spd = $signed({{(CW-SPEED_WIDTH){1'b0}}, speed});

    for (genvar g = 0; g < NUM_PADDLES; g++) begin : gPaddle
        paddle_hit_check #(
            .BIT_WIDTH    (BIT_WIDTH),
            .BALL_RADIUS  (BALL_RADIUS),
            .PADDLE_RADIUS(PADDLE_RADIUS),
            .SCREEN_W     (SCREEN_W)
        ) uCheck (
            .nx     (nx),
            .ny     (ny),
            .paddleX(paddleX[g*BIT_WIDTH +: BIT_WIDTH]),
            .paddleY(paddleY[g*BIT_WIDTH +: BIT_WIDTH]),
            .dirX   (dirX),
            .hit    (rawHit[g])
        );
    end

    always_comb begin
        hitSel = '0;
        anyHit = 1'b0;
        for (int i = 0; i < NUM_PADDLES; i++) begin
            if (rawHit[i] && !anyHit) begin
                hitSel[i] = 1'b1;
                anyHit    = 1'b1;
            end
        end
    end

    assign floorReached = (ny >= FLOOR_LIM);

    // A paddle bounce takes precedence over the side walls; the ceiling is independent.
    always_comb begin
        cx    = nx[BIT_WIDTH-1:0];
        cy    = ny[BIT_WIDTH-1:0];
        cDirX = dirX;
        cDirY = dirY;
        if (anyHit) begin
            cDirX = (dirX == DIR_RIGHT) ? DIR_LEFT : DIR_RIGHT;
        end else if (nx <= X_MIN) begin
            cx    = X_MIN[BIT_WIDTH-1:0];
            cDirX = DIR_RIGHT;
        end else if (nx >= X_MAX) begin
            cx    = X_MAX[BIT_WIDTH-1:0];
            cDirX = DIR_LEFT;
        end
        if (ny <= Y_MIN) begin
            cy    = Y_MIN[BIT_WIDTH-1:0];
            cDirY = DIR_DOWN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (serve) nextState = MOVE;
            MOVE:    if (frameTick) nextState = STEP;
            STEP:    nextState = CHECK;
            CHECK:   nextState = floorReached ? IDLE : MOVE;
            default: nextState = IDLE;
        endcase
    end

    // Event pulses are registered so they line up with the committed position.
    always_ff @(posedge clk) begin
        if (reset) begin
            ballX     <= BIT_WIDTH'(START_X);
            ballY     <= BIT_WIDTH'(START_Y);
            dirX      <= DIR_RIGHT;
            dirY      <= DIR_DOWN;
            nx        <= '0;
            ny        <= '0;
            hitPaddle <= '0;
            floorHit  <= 1'b0;
            hitCount  <= '0;
        end else begin
            hitPaddle <= '0;
            floorHit  <= 1'b0;
            case (state)
                IDLE: begin
                    if (serve) begin
                        dirX     <= serveDirX ? DIR_RIGHT : DIR_LEFT;
                        dirY     <= DIR_DOWN;
                        hitCount <= '0;
                    end
                end
                STEP: begin
                    nx <= (dirX == DIR_RIGHT) ? bx + spd : bx - spd;
                    ny <= (dirY == DIR_DOWN)  ? by + spd : by - spd;
                end
                CHECK: begin
                    if (floorReached) begin
                        floorHit <= 1'b1;
                        ballX    <= BIT_WIDTH'(START_X);
                        ballY    <= BIT_WIDTH'(START_Y);
                    end else begin
                        ballX <= cx;
                        ballY <= cy;
                        dirX  <= cDirX;
                        dirY  <= cDirY;
                        if (anyHit) begin
                            hitPaddle <= hitSel;
                            if (hitCount != '1) hitCount <= hitCount + HIT_CNT_WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
